// File: rtl/sb_hazard_unit_if.sv
// Pipeline <-> hazard unit bundle: ID-stage instruction fields, EX redirect,
// MC completion and WB retirement in one direction, and the stage controls back.
interface sb_hazard_unit_if #(
  parameter int AW = 5
);
  // ID stage instruction description
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_sb;
  logic          id_mc;
  logic          id_jal;
  // Later-stage events
  logic          ex_redirect;
  logic          mc_done;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic          wb_sb;
  // Pipeline controls produced by the hazard unit
  logic          stall_if;
  logic          flush_if;
  logic          flush_id;
  logic          flush_ex;
  logic          id_issue;
  logic          mc_busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_sb, id_mc, id_jal, ex_redirect, mc_done, wb_valid, wb_rd, wb_sb,
    input  stall_if, flush_if, flush_id, flush_ex, id_issue, mc_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_sb, id_mc, id_jal, ex_redirect, mc_done, wb_valid, wb_rd, wb_sb,
    output stall_if, flush_if, flush_id, flush_ex, id_issue, mc_busy
  );
endinterface

// File: rtl/sb_hazard_unit.sv
// Scoreboard hazard unit: per-register pending-write counters for results that
// cannot be forwarded at the next issue (loads, MUL/DIV), a single-MC-unit busy
// flag, IF/ID/EX stall and flush generation, a stall counter and an error flag.
module sb_hazard_unit #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CNTW = 2,
  parameter int PCW  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  sb_hazard_unit_if.slave  hz,
  input  logic             perf_clr,
  output logic [NREG-1:0]  pend_vec,
  output logic [PCW-1:0]   stall_cycles,
  output logic             sb_err
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [PCW-1:0]  PC_MAX  = '1;

  logic [CNTW-1:0] cnt_q [NREG];
  logic            mc_busy_q;

  logic raw, strc, sat, stall, issue;
  logic inc_en, dec_en, dec_err;

  // x0 and out-of-range addresses always read as "nothing pending".
  function automatic logic [CNTW-1:0] cnt_of(input logic [AW-1:0] a);
    if (a == '0 || int'(a) >= NREG) return '0;
    return cnt_q[a];
  endfunction

  // Hazard detection and pipeline controls, from registered state only.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    raw     = 1'b0;
    strc    = 1'b0;
    sat     = 1'b0;
    stall   = 1'b0;
    issue   = 1'b0;
    inc_en  = 1'b0;
    dec_en  = 1'b0;
    dec_err = 1'b0;
    if (hz.id_valid) begin
      raw  = (hz.id_rs1_used && cnt_of(hz.id_rs1) != '0) ||
             (hz.id_rs2_used && cnt_of(hz.id_rs2) != '0);
      strc = hz.id_mc && mc_busy_q;
      sat  = hz.id_sb && (hz.id_rd != '0) && (cnt_of(hz.id_rd) == CNT_MAX);
    end
    // A redirect kills the ID instruction, so it also cancels any stall on it.
    stall   = (raw || strc || sat) && !hz.ex_redirect;
    issue   = hz.id_valid && !stall && !hz.ex_redirect;
    inc_en  = issue && hz.id_sb && (hz.id_rd != '0);
    dec_en  = hz.wb_valid && hz.wb_sb && (hz.wb_rd != '0);
    dec_err = dec_en && (cnt_of(hz.wb_rd) == '0);
  end

  assign hz.stall_if = stall;
  assign hz.flush_ex = stall;
  assign hz.id_issue = issue;
  assign hz.flush_id = hz.ex_redirect;
  // A stalled JAL only kills the wrong-path fetch once it actually issues.
  assign hz.flush_if = hz.ex_redirect || (issue && hz.id_jal);
  assign hz.mc_busy  = mc_busy_q;

  // Pending-write counters: +1 on tracked issue, -1 on tracked WB, net zero on both.
  // NOTE: the counters are flops, not RAM, so they take the async reset; a stale
  // count surviving reset would stall its register forever.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        // NOTE: sequential state uses non-blocking assignment so every counter
        // sees the same pre-edge values regardless of statement order.
        if (inc_en && hz.id_rd == AW'(r) && !(dec_en && hz.wb_rd == AW'(r)))
          cnt_q[r] <= cnt_q[r] + CNTW'(1);
        else if (dec_en && hz.wb_rd == AW'(r) && !(inc_en && hz.id_rd == AW'(r)) &&
                 cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - CNTW'(1);
      end
    end
  end

  // MC unit occupancy and sticky protocol error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mc_busy_q <= 1'b0;
      sb_err    <= 1'b0;
    end else begin
      if (issue && hz.id_mc)
        mc_busy_q <= 1'b1;
      else if (hz.mc_done)
        mc_busy_q <= 1'b0;
      if (dec_err || (hz.mc_done && !mc_busy_q))
        sb_err <= 1'b1;
    end
  end

  // Saturating stall-cycle counter with synchronous clear taking priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cycles <= '0;
    else if (perf_clr)
      stall_cycles <= '0;
    else if (stall && stall_cycles != PC_MAX)
      stall_cycles <= stall_cycles + PCW'(1);
  end

  // Per-register pending view; x0 is never tracked.
  always_comb begin
    pend_vec = '0;
    for (int r = 1; r < NREG; r++) pend_vec[r] = (cnt_q[r] != '0);
  end

endmodule

// File: tb/tb_sb_hazard_unit.sv
// Randomised scoreboard bench for sb_hazard_unit: a driver issues one stimulus
// per cycle and queues the expected response from a behavioural model of
// pending writers; a negedge monitor pops and compares.
module tb_sb_hazard_unit;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CNTW = 2;
  localparam int PCW  = 4;
  localparam int CMAX = (1 << CNTW) - 1;
  localparam int SMAX = (1 << PCW) - 1;

  typedef struct {
    logic          id_valid;
    logic [AW-1:0] rs1, rs2, rd;
    logic          u1, u2, sb, mc, jal;
    logic          redir, mc_done, wb_valid, wb_sb, perf_clr;
    logic [AW-1:0] wb_rd;
  } stim_t;

  typedef struct {
    logic            stall_if, flush_if, flush_id, flush_ex, id_issue, mc_busy;
    logic [NREG-1:0] pend;
    logic [PCW-1:0]  stalls;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            perf_clr = 1'b0;
  logic [NREG-1:0] pend_vec;
  logic [PCW-1:0]  stall_cycles;
  logic            sb_err;

  sb_hazard_unit_if #(.AW(AW)) hz ();

  sb_hazard_unit #(.NREG(NREG), .AW(AW), .CNTW(CNTW), .PCW(PCW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .hz           (hz),
    .perf_clr     (perf_clr),
    .pend_vec     (pend_vec),
    .stall_cycles (stall_cycles),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  // Reference model: how many untretired non-forwardable writers target each register.
  int            pending[NREG];
  bit            unit_busy;
  int            stalls_m;
  bit            err_m;
  logic [AW-1:0] inflight[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.id_valid = 0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
    s.u1 = 0; s.u2 = 0; s.sb = 0; s.mc = 0; s.jal = 0;
    s.redir = 0; s.mc_done = 0; s.wb_valid = 0; s.wb_sb = 0; s.perf_clr = 0;
    s.wb_rd = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hz.id_valid = s.id_valid; hz.id_rs1 = s.rs1; hz.id_rs2 = s.rs2;
    hz.id_rs1_used = s.u1; hz.id_rs2_used = s.u2; hz.id_rd = s.rd;
    hz.id_sb = s.sb; hz.id_mc = s.mc; hz.id_jal = s.jal;
    hz.ex_redirect = s.redir; hz.mc_done = s.mc_done;
    hz.wb_valid = s.wb_valid; hz.wb_rd = s.wb_rd; hz.wb_sb = s.wb_sb;
    perf_clr = s.perf_clr;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) pending[r] = 0;
    unit_busy = 0; stalls_m = 0; err_m = 0;
    inflight.delete();
    exp_q.delete();
  endtask

  // One clock of stimulus: queue the expectation, then advance the model at the edge.
  task automatic step(input stim_t s, output bit issued);
    exp_t e;
    bit   reads_pending, unit_conflict, full, stall, issue, wr, rt, same;
    apply(s);
    reads_pending = s.id_valid &&
                    ((s.u1 && s.rs1 != 0 && pending[s.rs1] > 0) ||
                     (s.u2 && s.rs2 != 0 && pending[s.rs2] > 0));
    unit_conflict = s.id_valid && s.mc && unit_busy;
    full          = s.id_valid && s.sb && s.rd != 0 && pending[s.rd] == CMAX;
    stall = (reads_pending || unit_conflict || full) && !s.redir;
    issue = s.id_valid && !stall && !s.redir;
    e.stall_if = stall;
    e.flush_ex = stall;
    e.id_issue = issue;
    e.flush_id = s.redir;
    e.flush_if = s.redir || (issue && s.jal);
    e.mc_busy  = unit_busy;
    for (int r = 0; r < NREG; r++) e.pend[r] = (pending[r] > 0);
    e.stalls = PCW'(stalls_m);
    e.err    = err_m;
    exp_q.push_back(e);
    @(posedge clk);
    wr   = issue && s.sb && s.rd != 0;
    rt   = s.wb_valid && s.wb_sb && s.wb_rd != 0;
    same = wr && rt && s.rd == s.wb_rd;
    if (rt && pending[s.wb_rd] == 0) err_m = 1;
    if (!same) begin
      if (wr) pending[s.rd]++;
      if (rt && pending[s.wb_rd] > 0) pending[s.wb_rd]--;
    end
    if (wr) inflight.push_back(s.rd);
    if (s.mc_done && !unit_busy) err_m = 1;
    if (issue && s.mc) unit_busy = 1;
    else if (s.mc_done) unit_busy = 0;
    if (s.perf_clr) stalls_m = 0;
    else if (stall) stalls_m = (stalls_m < SMAX) ? stalls_m + 1 : SMAX;
    #1;
    issued = issue;
  endtask

  // Monitor: every cycle the DUT presents its controls; compare against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 expected=1");
      end else begin
        e = exp_q.pop_front();
        check("stall_if", 64'(hz.stall_if), 64'(e.stall_if));
        check("flush_if", 64'(hz.flush_if), 64'(e.flush_if));
        check("flush_id", 64'(hz.flush_id), 64'(e.flush_id));
        check("flush_ex", 64'(hz.flush_ex), 64'(e.flush_ex));
        check("id_issue", 64'(hz.id_issue), 64'(e.id_issue));
        check("mc_busy", 64'(hz.mc_busy), 64'(e.mc_busy));
        check("pend_vec", 64'(pend_vec), 64'(e.pend));
        check("stall_cycles", 64'(stall_cycles), 64'(e.stalls));
        check("sb_err", 64'(sb_err), 64'(e.err));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_stall_if"}, 64'(hz.stall_if), 64'd0);
    check({tag, "_flush_if"}, 64'(hz.flush_if), 64'd0);
    check({tag, "_flush_id"}, 64'(hz.flush_id), 64'd0);
    check({tag, "_flush_ex"}, 64'(hz.flush_ex), 64'd0);
    check({tag, "_id_issue"}, 64'(hz.id_issue), 64'd0);
    check({tag, "_mc_busy"}, 64'(hz.mc_busy), 64'd0);
    check({tag, "_pend_vec"}, 64'(pend_vec), 64'd0);
    check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd0);
    check({tag, "_sb_err"}, 64'(sb_err), 64'd0);
  endtask

  task automatic restart();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    stim_t s, a, cur;
    bit    iss, need_new, late;
    int    kind;

    apply(nop());
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    restart();

    // Load-use: load x5, then a consumer of x5 waits until the WB is visible.
    s = nop(); s.id_valid = 1; s.rd = 5; s.sb = 1;
    step(s, iss);
    a = nop(); a.id_valid = 1; a.rs1 = 5; a.u1 = 1; a.rd = 6;
    step(a, iss);
    step(a, iss);
    a.wb_valid = 1; a.wb_rd = 5; a.wb_sb = 1;
    step(a, iss);
    a.wb_valid = 0; a.wb_sb = 0;
    step(a, iss);
    check("loaduse_issued", 64'(iss), 64'd1);
    check("loaduse_stall_cycles", 64'(stall_cycles), 64'd3);

    // MC structural: DIV occupies the unit, MUL waits for mc_done, then issues.
    s = nop(); s.id_valid = 1; s.mc = 1; s.sb = 1; s.rd = 10;
    step(s, iss);
    a = nop(); a.id_valid = 1; a.mc = 1; a.sb = 1; a.rd = 11; a.rs1 = 1; a.u1 = 1;
    step(a, iss);
    step(a, iss);
    a.mc_done = 1;
    step(a, iss);
    a.mc_done = 0;
    step(a, iss);
    check("mc_second_issued", 64'(iss), 64'd1);
    s = nop(); s.mc_done = 1;
    step(s, iss);
    s = nop(); s.wb_valid = 1; s.wb_sb = 1; s.wb_rd = 10;
    step(s, iss);
    s.wb_rd = 11;
    step(s, iss);
    step(nop(), iss);

    // Reset asserted while a load-use stall is active clears state asynchronously.
    s = nop(); s.id_valid = 1; s.rd = 5; s.sb = 1;
    step(s, iss);
    mon_en = 1'b0;
    a = nop(); a.id_valid = 1; a.rs1 = 5; a.u1 = 1;
    apply(a);
    #2;
    check("prereset_stall_if", 64'(hz.stall_if), 64'd1);
    rstn = 1'b0;
    #1;
    check("midreset_stall_if", 64'(hz.stall_if), 64'd0);
    check("midreset_pend_vec", 64'(pend_vec), 64'd0);
    apply(nop());
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    restart();

    // Randomised traffic: a held ID instruction, random redirects, WBs and MC completions.
    need_new = 1;
    cur = nop();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      late = (cyc >= 3600);
      if (need_new) begin
        cur = nop();
        cur.id_valid = ($urandom_range(0, 4) != 0);
        cur.rs1 = AW'($urandom_range(0, 5));
        cur.rs2 = AW'($urandom_range(0, 5));
        cur.rd  = AW'($urandom_range(0, 5));
        cur.u1  = ($urandom_range(0, 3) != 0);
        cur.u2  = ($urandom_range(0, 1) != 0);
        kind = int'($urandom_range(0, 3));
        case (kind)
          1: cur.sb = 1;
          2: begin cur.sb = 1; cur.mc = 1; end
          3: cur.jal = 1;
          default: ;
        endcase
      end
      s = cur;
      s.redir    = ($urandom_range(0, 19) == 0);
      s.perf_clr = ($urandom_range(0, 99) == 0);
      if (unit_busy) s.mc_done = ($urandom_range(0, 2) == 0);
      else if (late) s.mc_done = ($urandom_range(0, 24) == 0);
      if (inflight.size() > 0 && $urandom_range(0, 4) < 2) begin
        s.wb_valid = 1; s.wb_sb = 1; s.wb_rd = inflight.pop_front();
      end else if (late && !s.id_valid && $urandom_range(0, 29) == 0) begin
        s.wb_valid = 1; s.wb_sb = 1; s.wb_rd = AW'($urandom_range(1, 5));
      end else begin
        s.wb_valid = ($urandom_range(0, 3) == 0); s.wb_sb = 0;
        s.wb_rd = AW'($urandom_range(0, 5));
      end
      step(s, iss);
      need_new = iss || s.redir || !s.id_valid;
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_hazard_unit.md
Name: sb_hazard_unit

Overview:
Parametrised scoreboard-based hazard unit that replaces fixed load-use detection. It tracks per-register pending-write counts for producers whose results cannot be forwarded at the next issue: loads and multi-cycle (MC) ops such as MUL/DIV. It generates stall, bubble and flush controls for IF/ID/EX and handles the structural hazard on a single MC unit. It sits beside the ID stage; data forwarding stays in the separate forwarding logic.

Parameters:
NREG, 32, number of architectural registers (x0 hardwired zero, never tracked)
AW, 5, register address width; NREG <= 2**AW
CNTW, 2, per-register pending counter width; max in-flight tracked writers per register = 2**CNTW-1
PCW, 32, stall performance counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
id_valid  in  1  valid instruction in ID
id_rs1  in  AW  ID source 1
id_rs2  in  AW  ID source 2
id_rs1_used  in  1  rs1 is read
id_rs2_used  in  1  rs2 is read
id_rd  in  AW  ID destination
id_sb  in  1  ID writes rd with a non-forwardable result (load or MC)
id_mc  in  1  ID uses the MC unit
id_jal  in  1  ID is JAL
ex_redirect  in  1  EX branch taken or JALR
mc_done  in  1  MC unit finished; unit free next cycle
wb_valid  in  1  WB stage valid
wb_rd  in  AW  WB destination
wb_sb  in  1  WB instruction was scoreboarded
perf_clr  in  1  synchronous clear of stall_cycles
stall_if  out  1  hold PC and IF/ID
flush_if  out  1  kill IF/ID
flush_id  out  1  kill ID/EX input (ID instruction not issued)
flush_ex  out  1  insert bubble into EX
id_issue  out  1  ID instruction advances to EX this cycle
mc_busy  out  1  MC unit occupied (registered)
pend_vec  out  NREG  bit r = (cnt[r] != 0)
stall_cycles  out  PCW  saturating count of stall_if cycles
sb_err  out  1  sticky protocol error flag

Behaviour:
- State: cnt[1..NREG-1] (CNTW bits each), mc_busy_q, stall_cycles, sb_err. cnt[0] is constant 0.
- Async reset (rstn=0): all cnt=0, mc_busy=0, stall_cycles=0, sb_err=0. Outputs therefore reset to 0 (combinational outputs are 0 when no inputs are active). Reset asserted mid-operation discards all pending state immediately.
- Hazard terms use registered state only. A WB decrement in cycle N is visible in N+1 (one-cycle conservative):
  - raw = id_valid & ((id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0) | (id_rs2_used & id_rs2!=0 & cnt[id_rs2]!=0))
  - strc = id_valid & id_mc & mc_busy_q
  - sat = id_valid & id_sb & id_rd!=0 & cnt[id_rd]==all-ones
- stall = (raw|strc|sat) & ~ex_redirect. ex_redirect has top priority.
- stall_if = flush_ex = stall.
- id_issue = id_valid & ~stall & ~ex_redirect.
- flush_id = ex_redirect.
- flush_if = ex_redirect | (id_issue & id_jal). A stalled JAL does not flush until it issues.
- Counter update, per clock:
  - inc = id_issue & id_sb & id_rd!=0 at id_rd
  - dec = wb_valid & wb_sb & wb_rd!=0 at wb_rd
  - Both on the same register: count unchanged.
  - Dec when cnt==0: count stays 0, sb_err<=1.
  - Overflow is impossible because of sat.
- ex_redirect never modifies counters. Killed ID instructions were never marked.
- mc_busy_q: set on id_issue&id_mc; cleared on mc_done. mc_done with mc_busy_q=0 sets sb_err and is otherwise ignored. mc_done and a new issue in the same cycle cannot occur because strc blocks the issue.
- stall_cycles:
  - perf_clr: 0 (clear wins).
  - Else if stall_if: +1, saturating at all-ones.
- sb_err is cleared only by reset.

Test Plan:
- Load-use: cycle0 issue load rd=5 (id_sb=1). Cycle1 ID add rs1=5 -> stall_if=flush_ex=1, id_issue=0, pend_vec[5]=1. Cycle3 wb_rd=5,wb_sb=1 -> cycle4 stall_if=0, id_issue=1, stall_cycles=3.
- WAW: issue two loads rd=7 back-to-back -> cnt[7]=2. First WB -> pend_vec[7] still 1. Second WB -> pend_vec[7]=0.
- Saturation (CNTW=2): three loads rd=9 issue -> cnt=3. Fourth load rd=9 stalls until one WB, then issues the next cycle.
- MC structural: DIV issues -> mc_busy=1. Following MUL stalls. mc_done at cycle5 -> MUL issues cycle6, mc_busy stays 1.
- Redirect during stall: raw stall active, ex_redirect=1 -> stall_if=0, flush_if=flush_id=1, id_issue=0, cnt unchanged. stall_cycles not incremented that cycle.
- Edge/errors: load rd=0 -> pend_vec unchanged. WB wb_sb rd=3 with cnt[3]=0 -> sb_err=1, cnt[3]=0. rstn low mid-stall -> all outputs 0 asynchronously.
